// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake and a per-bit baud counter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_dat_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    logic parity_r;
    logic parity_s;
`endif

    logic [2:0]       state_r;
    logic [2:0]       state_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [CNT_W-1:0] baud_cnt_s;
    logic [2:0]       bit_cnt_r;
    logic [2:0]       bit_cnt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic             ready_s;
    logic             line_s;
    logic             busy_s;
    logic             done_s;
    logic             baud_last_s;

    assign baud_last_s = (baud_cnt_r == BAUD_LAST);

    // Next-state and next-output computation; outputs are the registered form of these.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        ready_s    = 1'b0;
        line_s     = 1'b1;
        busy_s     = 1'b1;
        done_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            IDLE: begin
                baud_cnt_s = BAUD_ZERO;
                bit_cnt_s  = 3'd0;
                busy_s     = 1'b0;
                if (tx_valid && tx_ready) begin
                    shift_s  = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_s = even_parity(tx_data);
`endif
                    state_s  = START;
                    line_s   = 1'b0;
                    busy_s   = 1'b1;
                end else begin
                    ready_s  = 1'b1;
                end
            end
            START: begin
                line_s = 1'b0;
                if (baud_last_s) begin
                    baud_cnt_s = BAUD_ZERO;
                    state_s    = DATA;
                    line_s     = shift_r[0];
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            DATA: begin
                line_s = shift_r[0];
                if (baud_last_s) begin
                    baud_cnt_s = BAUD_ZERO;
                    shift_s    = {1'b0, shift_r[7:1]};
                    bit_cnt_s  = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
                        line_s  = parity_r;
`else
                        state_s = STOP;
                        line_s  = 1'b1;
`endif
                    end else begin
                        // Present the next data bit on the same edge the shift happens.
                        line_s = shift_r[1];
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_s = parity_r;
                if (baud_last_s) begin
                    baud_cnt_s = BAUD_ZERO;
                    state_s    = STOP;
                    line_s     = 1'b1;
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
`endif
            STOP: begin
                line_s = 1'b1;
                if (baud_last_s) begin
                    baud_cnt_s = BAUD_ZERO;
                    state_s    = IDLE;
                    ready_s    = 1'b1;
                    busy_s     = 1'b0;
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                    // Registered pulse lands on the final stop-bit cycle.
                    done_s     = (baud_cnt_r == BAUD_PRE);
                end
            end
            default: begin
                state_s    = IDLE;
                baud_cnt_s = BAUD_ZERO;
                bit_cnt_s  = 3'd0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r        <= IDLE;
            baud_cnt_r     <= BAUD_ZERO;
            bit_cnt_r      <= 3'd0;
            shift_r        <= 8'h00;
            tx_ready       <= 1'b0;
            serial_dat_out <= 1'b1;
            tx_busy        <= 1'b0;
            tx_done        <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r       <= 1'b0;
`endif
        end else begin
            state_r        <= state_s;
            baud_cnt_r     <= baud_cnt_s;
            bit_cnt_r      <= bit_cnt_s;
            shift_r        <= shift_s;
            tx_ready       <= ready_s;
            serial_dat_out <= line_s;
            tx_busy        <= busy_s;
            tx_done        <= done_s;
`ifdef UART_TX_PARITY_EN
            parity_r       <= parity_s;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: cycle-exact frame checks plus a line monitor
// that decodes frames and compares them against a queue of expected bytes.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int FRAME = SLOTS * CPB;

    logic       clk;
    logic       rstn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       serial_dat_out;
    logic       tx_busy;
    logic       tx_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];

    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    int         mon_slot   = 0;
    logic [7:0] mon_byte   = 8'h00;
    logic [7:0] mon_exp;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .serial_dat_out (serial_dat_out),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_line(input logic [7:0] d, input int slot);
        if (slot == 0) return 1'b0;
        else if (slot <= 8) return d[slot-1];
`ifdef UART_TX_PARITY_EN
        else if (slot == 9) return ^d;
`endif
        else return 1'b1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a byte, wait (bounded) for acceptance, return on the first negedge of the frame.
    task automatic start_byte(input logic [7:0] data);
        int n = 0;
        tx_data  = data;
        tx_valid = 1'b1;
        exp_q.push_back(data);
        while (tx_ready !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4 * FRAME) check_eq("accept_timeout", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_frame(input logic [7:0] data);
        for (int j = 0; j < FRAME; j++) begin
            check_eq($sformatf("line_%0h_%0d", data, j), {31'd0, serial_dat_out}, {31'd0, exp_line(data, j / CPB)});
            check_eq($sformatf("done_%0h_%0d", data, j), {31'd0, tx_done}, {31'd0, (j == FRAME - 1)});
            check_eq("busy_in_frame", {31'd0, tx_busy}, 32'd1);
            check_eq("ready_in_frame", {31'd0, tx_ready}, 32'd0);
            @(negedge clk);
        end
        check_eq("ret_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("ret_busy", {31'd0, tx_busy}, 32'd0);
        check_eq("ret_line", {31'd0, serial_dat_out}, 32'd1);
        check_eq("ret_done", {31'd0, tx_done}, 32'd0);
    endtask

    // Line monitor: samples mid-bit and scores each completed frame.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active) begin
                    if (serial_dat_out == 1'b0) begin
                        mon_active = 1'b1;
                        mon_cnt    = 0;
                    end
                end else begin
                    mon_cnt++;
                end
                if (mon_active && (mon_cnt % CPB) == CPB / 2) begin
                    mon_slot = mon_cnt / CPB;
                    if (mon_slot == 0) begin
                        check_eq("mon_start", {31'd0, serial_dat_out}, 32'd0);
                    end else if (mon_slot <= 8) begin
                        mon_byte[mon_slot-1] = serial_dat_out;
`ifdef UART_TX_PARITY_EN
                    end else if (mon_slot == 9) begin
                        check_eq("mon_parity", {31'd0, serial_dat_out}, {31'd0, ^mon_byte});
`endif
                    end else begin
                        check_eq("mon_stop", {31'd0, serial_dat_out}, 32'd1);
                        if (exp_q.size() == 0) begin
                            check_eq("mon_queue", 32'(exp_q.size()), 32'd1);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            check_eq("mon_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
                        end
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, run %0d failed %0d", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1 rstn  = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_line", {31'd0, serial_dat_out}, 32'd1);
            check_eq("rst_ready", {31'd0, tx_ready}, 32'd0);
            check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
            check_eq("rst_done", {31'd0, tx_done}, 32'd0);
        end
        rstn = 1'b1;
        step(1);
        check_eq("post_rst_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("post_rst_busy", {31'd0, tx_busy}, 32'd0);
        check_eq("post_rst_line", {31'd0, serial_dat_out}, 32'd1);

        // Single byte with exact waveform and done position
        start_byte(8'hA5);
        tx_valid = 1'b0;
        check_frame(8'hA5);

        // Back-to-back with tx_valid held high
        start_byte(8'h00);
        tx_data = 8'hFF;
        exp_q.push_back(8'hFF);
        step(FRAME);
        check_eq("b2b_gap_line", {31'd0, serial_dat_out}, 32'd1);
        check_eq("b2b_gap_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("b2b_gap_busy", {31'd0, tx_busy}, 32'd0);
        step(1);
        check_eq("b2b_start_line", {31'd0, serial_dat_out}, 32'd0);
        check_eq("b2b_start_busy", {31'd0, tx_busy}, 32'd1);
        tx_valid = 1'b0;
        step(FRAME);
        check_eq("b2b_end_ready", {31'd0, tx_ready}, 32'd1);

        // Request arriving mid-frame waits for IDLE
        start_byte(8'h55);
        tx_valid = 1'b0;
        step(11);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        exp_q.push_back(8'h3C);
        for (int j = 11; j < FRAME; j++) begin
            check_eq($sformatf("mid_ready_%0d", j), {31'd0, tx_ready}, 32'd0);
            step(1);
        end
        check_eq("mid_idle_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("mid_idle_line", {31'd0, serial_dat_out}, 32'd1);
        step(1);
        check_eq("mid_next_busy", {31'd0, tx_busy}, 32'd1);
        check_eq("mid_next_line", {31'd0, serial_dat_out}, 32'd0);
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        step(FRAME);
        check_eq("mid_end_ready", {31'd0, tx_ready}, 32'd1);

        // Asynchronous reset during data bit 3
        start_byte(8'hF0);
        tx_valid = 1'b0;
        step(17);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_line", {31'd0, serial_dat_out}, 32'd1);
        check_eq("arst_busy", {31'd0, tx_busy}, 32'd0);
        check_eq("arst_ready", {31'd0, tx_ready}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("arst_hold_done", {31'd0, tx_done}, 32'd0);
            check_eq("arst_hold_line", {31'd0, serial_dat_out}, 32'd1);
        end
        rstn = 1'b1;
        step(1);
        check_eq("arst_rel_ready", {31'd0, tx_ready}, 32'd1);
        start_byte(8'h81);
        tx_valid = 1'b0;
        check_frame(8'h81);

`ifdef UART_TX_PARITY_EN
        start_byte(8'h07);
        tx_valid = 1'b0;
        check_frame(8'h07);
        start_byte(8'h03);
        tx_valid = 1'b0;
        check_frame(8'h03);
`endif

        step(2);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
